// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Issues one access per cycle and routes read data back by a latency-matched tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  p0_valid,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  output logic                  p0_ready,
  output logic                  p0_read_valid,
  output logic [DATA_WIDTH-1:0] p0_read_data,

  input  logic                  p1_valid,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic                  p1_ready,
  output logic                  p1_read_valid,
  output logic [DATA_WIDTH-1:0] p1_read_data,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic {
    PRI_P0 = 1'b0,
    PRI_P1 = 1'b1
  } pri_e;

  pri_e pri_q, pri_d;

  logic grant0, grant1, xfer;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;

  // Stage 0 is loaded on the issue edge; stage READ_LATENCY is the head.
  logic [READ_LATENCY:0] tag_rd_q, tag_rd_d;
  logic [READ_LATENCY:0] tag_port_q, tag_port_d;
  logic                  head_rd, head_port;

  logic                  p0_rv_q, p0_rv_d;
  logic                  p1_rv_q, p1_rv_d;
  logic [DATA_WIDTH-1:0] p0_rd_q, p0_rd_d;
  logic [DATA_WIDTH-1:0] p1_rd_q, p1_rd_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (p0_valid && p1_valid) begin
        grant0 = (pri_q == PRI_P0);
        grant1 = (pri_q == PRI_P1);
      end else begin
        grant0 = p0_valid;
        grant1 = p1_valid;
      end
    end
    xfer = grant0 | grant1;
  end

  assign p0_ready = grant0;
  assign p1_ready = grant1;

  always_comb begin
    pri_d   = pri_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    if (grant0) begin
      pri_d   = PRI_P1;
      addr_d  = p0_address;
      wdata_d = p0_write_data;
      we_d    = p0_write;
    end else if (grant1) begin
      pri_d   = PRI_P0;
      addr_d  = p1_address;
      wdata_d = p1_write_data;
      we_d    = p1_write;
    end

    // Idle cycles and writes both shift in a non-read tag, so only reads respond.
    tag_rd_d   = {tag_rd_q[READ_LATENCY-1:0], xfer && !we_d};
    tag_port_d = {tag_port_q[READ_LATENCY-1:0], grant1};

    head_rd   = tag_rd_q[READ_LATENCY];
    head_port = tag_port_q[READ_LATENCY];

    p0_rv_d = head_rd && !head_port;
    p1_rv_d = head_rd && head_port;
    p0_rd_d = p0_rv_d ? mem_read_data : p0_rd_q;
    p1_rd_d = p1_rv_d ? mem_read_data : p1_rd_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pri_q      <= PRI_P0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      tag_rd_q   <= '0;
      tag_port_q <= '0;
      p0_rv_q    <= 1'b0;
      p1_rv_q    <= 1'b0;
      p0_rd_q    <= '0;
      p1_rd_q    <= '0;
    end else begin
      pri_q      <= pri_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      tag_rd_q   <= tag_rd_d;
      tag_port_q <= tag_port_d;
      p0_rv_q    <= p0_rv_d;
      p1_rv_q    <= p1_rv_d;
      p0_rd_q    <= p0_rd_d;
      p1_rd_q    <= p1_rd_d;
    end
  end

  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = we_q;
  assign p0_read_valid    = p0_rv_q;
  assign p0_read_data     = p0_rd_q;
  assign p1_read_valid    = p1_rv_q;
  assign p1_read_data     = p1_rd_q;

endmodule
